predecode_fetch_queue: RTL

//  Parametrised instruction fetch queue between the fetch unit and decode.

---
 rtl/predecode_fetch_queue_if.sv | 26 ++
 rtl/predecode_fetch_queue.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/predecode_fetch_queue_if.sv
// Handshake bundle between fetch, the predecode fetch queue and decode.
// The queue takes the slave view; the fetch/decode side takes the master view.
interface predecode_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     in_instr_i;
  logic [XLEN-1:0] in_pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [31:0]     out_instr_o;
  logic [XLEN-1:0] out_pc_o;
  logic [3:0]      out_class_o;
  logic            out_is_ctrl_o;

  modport slave (
    input  in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_class_o, out_is_ctrl_o
  );

  modport master (
    output in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_class_o, out_is_ctrl_o
  );
endinterface

// File: rtl/predecode_fetch_queue.sv
// Instruction fetch queue that predecodes each word into an opcode class on write.
// Flush empties the queue in one cycle; an empty queue presents a NOP.
package opcodes_pkg;
  localparam logic [6:0] LW_OPCODE        = 7'b0000011;
  localparam logic [6:0] SW_OPCODE        = 7'b0100011;
  localparam logic [6:0] JAL_OPCODE       = 7'b1101111;
  localparam logic [6:0] LUI_OPCODE       = 7'b0110111;
  localparam logic [6:0] CSR_OPCODE       = 7'b1110011;
  localparam logic [6:0] JALR_OPCODE      = 7'b1100111;
  localparam logic [6:0] AUIPC_OPCODE     = 7'b0010111;
  localparam logic [6:0] BRANCH_OPCODE    = 7'b1100011;
  localparam logic [6:0] IMMEDIATE_OPCODE = 7'b0010011;
  localparam logic [6:0] RTYPE_OPCODE     = 7'b0110011;
  localparam logic [6:0] ATOMIC_OPCODE    = 7'b0101111;
  localparam logic [6:0] FENCE_OPCODE     = 7'b0001111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

  typedef enum logic [3:0] {
    CLS_LW        = 4'd0,
    CLS_SW        = 4'd1,
    CLS_JAL       = 4'd2,
    CLS_LUI       = 4'd3,
    CLS_CSR       = 4'd4,
    CLS_JALR      = 4'd5,
    CLS_AUIPC     = 4'd6,
    CLS_BRANCH    = 4'd7,
    CLS_IMMEDIATE = 4'd8,
    CLS_RTYPE     = 4'd9,
    CLS_ATOMIC    = 4'd10,
    CLS_FENCE     = 4'd11,
    CLS_ILLEGAL   = 4'd15
  } instr_class_e;
endpackage

module predecode_fetch_queue
  import opcodes_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  predecode_fetch_queue_if.slave   bus,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Every legal opcode ends in 2'b11, so compressed encodings fall to ILLEGAL.
  function automatic instr_class_e classify(input logic [6:0] opcode);
    case (opcode)
      LW_OPCODE:        classify = CLS_LW;
      SW_OPCODE:        classify = CLS_SW;
      JAL_OPCODE:       classify = CLS_JAL;
      LUI_OPCODE:       classify = CLS_LUI;
      CSR_OPCODE:       classify = CLS_CSR;
      JALR_OPCODE:      classify = CLS_JALR;
      AUIPC_OPCODE:     classify = CLS_AUIPC;
      BRANCH_OPCODE:    classify = CLS_BRANCH;
      IMMEDIATE_OPCODE: classify = CLS_IMMEDIATE;
      RTYPE_OPCODE:     classify = CLS_RTYPE;
      ATOMIC_OPCODE:    classify = CLS_ATOMIC;
      FENCE_OPCODE:     classify = CLS_FENCE;
      default:          classify = CLS_ILLEGAL;
    endcase
  endfunction

  logic [31:0]     r_instr_mem [DEPTH];
  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [3:0]      r_class_mem [DEPTH];
  logic            r_ctrl_mem  [DEPTH];

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  instr_class_e    w_in_class;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;

  assign w_in_ready  = (r_count < CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid_i && w_in_ready && !flush_i;
  assign w_pop       = w_out_valid && bus.out_ready_i && !flush_i;
  assign w_in_class  = classify(bus.in_instr_i[6:0]);

  // NOTE: storage has no reset; the pointers and count alone decide what is valid,
  // and leaving the array unreset keeps it a plain register file/RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= bus.in_instr_i;
      r_pc_mem[r_wr_ptr]    <= bus.in_pc_i;
      r_class_mem[r_wr_ptr] <= w_in_class;
      r_ctrl_mem[r_wr_ptr]  <= (w_in_class == CLS_JAL) || (w_in_class == CLS_JALR) ||
                               (w_in_class == CLS_BRANCH);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: empty-state values are assigned first so no path through this block
  // leaves an output unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.out_instr_o   = NOP_INSTR;
    bus.out_pc_o      = '0;
    bus.out_class_o   = CLS_RTYPE;
    bus.out_is_ctrl_o = 1'b0;
    if (w_out_valid) begin
      bus.out_instr_o   = r_instr_mem[r_rd_ptr];
      bus.out_pc_o      = r_pc_mem[r_rd_ptr];
      bus.out_class_o   = r_class_mem[r_rd_ptr];
      bus.out_is_ctrl_o = r_ctrl_mem[r_rd_ptr];
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign count_o         = r_count;
endmodule
